ps2_key_decoder: RTL and testbench

Receives PS/2 keyboard frames and turns the seven gameplay keys (Z X C V B N M) into a held/pressed view. It drives `key_state` and `keys` into `track_control`, which judges hits against falling notes. It runs on the 65 MHz system clock and tracks make/break codes, so `key_state` stays high for as long as a mapped key is physically held.

---
 rtl/ps2_pkg.sv | 74 +++++++
 rtl/ps2_rx.sv | 140 ++++++++++++++
 rtl/ps2_key_decoder.sv | 75 +++++++
 tb/tb_ps2_key_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, scan-code constants and lookup helpers for the PS/2 key decoder
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  // Set-2 make codes of the seven gameplay keys, in key-index order
  localparam logic [7:0] SC_Z = 8'h1A;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_M = 8'h3A;

  localparam int NUM_KEYS = 7;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } key_lookup_t;

  // Maps a scan code to its key index; valid is low for codes we do not track
  function automatic key_lookup_t scan_to_idx(input logic [7:0] code);
    key_lookup_t r;
    r.valid = 1'b1;
    r.idx   = 3'd0;
    case (code)
      SC_Z:    r.idx = 3'd0;
      SC_X:    r.idx = 3'd1;
      SC_C:    r.idx = 3'd2;
      SC_V:    r.idx = 3'd3;
      SC_B:    r.idx = 3'd4;
      SC_N:    r.idx = 3'd5;
      SC_M:    r.idx = 3'd6;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // Upper-case ASCII of each key index
  function automatic logic [7:0] idx_to_ascii(input logic [2:0] idx);
    logic [7:0] a;
    case (idx)
      3'd0:    a = 8'h5a;
      3'd1:    a = 8'h58;
      3'd2:    a = 8'h43;
      3'd3:    a = 8'h56;
      3'd4:    a = 8'h42;
      3'd5:    a = 8'h4e;
      3'd6:    a = 8'h4d;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Lowest set index of a held mask (0 when the mask is empty)
  function automatic logic [2:0] lowest_held(input logic [NUM_KEYS-1:0] mask);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver (sync, clock filter, FSM, timeout); parity check under PS2_PARITY_CHECK_EN
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          frame_ok;
  logic          byte_valid_nxt, frame_err_nxt;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_bit;
`endif

  // Two-flop synchronizers; the bus idles high
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level follows only after FILTER_LEN differing samples; falling change strobes a bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
        strobe   <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dat_s2 & (^{shift_reg, par_bit});
`else
  assign frame_ok = dat_s2;
`endif

  assign timeout = (state != RX_IDLE) && (to_cnt == TO_LIMIT);

  // Next-state and one-cycle result pulses; a stalled frame is abandoned ahead of any strobe
  always_comb begin
    state_nxt      = state;
    byte_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    if (timeout) begin
      state_nxt     = RX_IDLE;
      frame_err_nxt = 1'b1;
    end else if (strobe) begin
      case (state)
        RX_IDLE: begin
          if (!dat_s2) state_nxt = RX_DATA;
          else         frame_err_nxt = 1'b1;
        end
        RX_DATA: begin
          if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
        end
        RX_PARITY: state_nxt = RX_STOP;
        RX_STOP: begin
          state_nxt = RX_IDLE;
          if (frame_ok) byte_valid_nxt = 1'b1;
          else          frame_err_nxt  = 1'b1;
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  // State, shift register, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      byte_valid <= byte_valid_nxt;
      frame_err  <= frame_err_nxt;
      if (strobe || state == RX_IDLE) to_cnt <= '0;
      else                            to_cnt <= to_cnt + TW'(1);
      if (state == RX_IDLE) bit_cnt <= '0;
      if (strobe && state == RX_DATA) begin
        shift_reg <= {dat_s2, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
`ifdef PS2_PARITY_CHECK_EN
      if (strobe && state == RX_PARITY) par_bit <= dat_s2;
`endif
      if (byte_valid_nxt) rx_byte <= shift_reg;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - make/break decoder turning PS/2 bytes into a held-key mask (PS2_PARITY_CHECK_EN passes to ps2_rx)
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                key_state,
  output logic [7:0]          keys,
  output logic [NUM_KEYS-1:0] held,
  output logic                frame_err
);

  logic [7:0]          rx_byte;
  logic                byte_valid;
  logic                brk, ext;
  key_lookup_t         lookup;
  logic [NUM_KEYS-1:0] remain;
  logic [7:0]          key_ascii;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Decode the incoming byte and the keys that stay down if it is a release
  always_comb begin
    lookup    = scan_to_idx(rx_byte);
    key_ascii = idx_to_ascii(lookup.idx);
    remain    = held & ~(7'b1 << lookup.idx);
  end

  // Prefix flags and held mask; a release of the displayed key falls back to the lowest key still down
  always_ff @(posedge clk) begin
    if (!rst) begin
      brk  <= 1'b0;
      ext  <= 1'b0;
      held <= '0;
      keys <= 8'h00;
    end else if (byte_valid) begin
      if (rx_byte == CODE_BREAK) begin
        brk <= 1'b1;
      end else if (rx_byte == CODE_EXT) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
        if (!ext && lookup.valid) begin
          if (!brk) begin
            held[lookup.idx] <= 1'b1;
            keys             <= key_ascii;
          end else begin
            held[lookup.idx] <= 1'b0;
            if (keys == key_ascii && |remain) keys <= idx_to_ascii(lowest_held(remain));
          end
        end
      end
    end
  end

  assign key_state = |held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder; expectations follow PS2_PARITY_CHECK_EN
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_state;
  logic [7:0] keys;
  logic [6:0] held;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int e0;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    logic [6:0] exp_held;
    logic [7:0] exp_keys;
    int         exp_errs;
  } vec_t;

  vec_t vecs[$];

`ifdef PS2_PARITY_CHECK_EN
  localparam logic [6:0] H_FINAL = 7'h01;
`else
  localparam logic [6:0] H_FINAL = 7'h21;
`endif

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_state(key_state),
    .keys     (keys),
    .held     (held),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt <= err_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic [6:0] h, input logic [7:0] k);
    check({tag, "_held"}, 32'(held), 32'(h));
    check({tag, "_keys"}, 32'(keys), 32'(k));
    check({tag, "_key_state"}, 32'(key_state), 32'(|h));
  endtask

  initial begin
    vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h1A, 1'b0, 1'b0, 7'h00, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h1A, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h3A, 1'b0, 1'b0, 7'h41, 8'h4d, 0});
    vecs.push_back(vec_t'{8'h3A, 1'b0, 1'b0, 7'h41, 8'h4d, 0});
    vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b0, 7'h41, 8'h4d, 0});
    vecs.push_back(vec_t'{8'h3A, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'hE0, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h1A, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h22, 1'b0, 1'b0, 7'h03, 8'h58, 0});
    vecs.push_back(vec_t'{8'h21, 1'b0, 1'b0, 7'h07, 8'h43, 0});
    vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b0, 7'h07, 8'h43, 0});
    vecs.push_back(vec_t'{8'h21, 1'b0, 1'b0, 7'h03, 8'h5a, 0});
    vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b0, 7'h03, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h22, 1'b0, 1'b0, 7'h01, 8'h5a, 0});
    vecs.push_back(vec_t'{8'h22, 1'b0, 1'b1, 7'h01, 8'h5a, 1});
`ifdef PS2_PARITY_CHECK_EN
    vecs.push_back(vec_t'{8'h31, 1'b1, 1'b0, 7'h01, 8'h5a, 1});
`else
    vecs.push_back(vec_t'{8'h31, 1'b1, 1'b0, 7'h21, 8'h4e, 0});
`endif

    // Reset state
    repeat (4) @(negedge clk);
    check_outputs("reset", 7'h00, 8'h00);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Latency: held moves exactly 12 cycles after the raw stop-bit falling edge
    send_bits(make_frame(8'h1A, 1'b0, 1'b0), 10);
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (11) @(negedge clk);
    check("lat_before_held", 32'(held), 32'h00);
    @(negedge clk);
    check_outputs("lat_after", 7'h01, 8'h5a);
    repeat (28) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);

    // Table of whole frames
    for (int i = 0; i < vecs.size(); i++) begin
      e0 = err_cnt;
      send_bits(make_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop), 11);
      check_outputs($sformatf("v%0d", i), vecs[i].exp_held, vecs[i].exp_keys);
      check($sformatf("v%0d_errs", i), 32'(err_cnt - e0), 32'(vecs[i].exp_errs));
    end

    // Lone strobe with data high in IDLE is a start-bit violation
    e0 = err_cnt;
    send_bit(1'b1);
    check("start_err", 32'(err_cnt - e0), 32'd1);
    check("start_err_held", 32'(held), 32'(H_FINAL));

    // Partial frame then silence: one timeout pulse, then a clean frame decodes
    e0 = err_cnt;
    send_bits(make_frame(8'h22, 1'b0, 1'b0), 4);
    repeat (TIMEOUT_CYCLES - 300) @(negedge clk);
    check("to_early", 32'(err_cnt - e0), 32'd0);
    repeat (500) @(negedge clk);
    check("to_err", 32'(err_cnt - e0), 32'd1);
    send_bits(make_frame(8'h22, 1'b0, 1'b0), 11);
    check_outputs("after_to", H_FINAL | 7'h02, 8'h58);
    check("after_to_errs", 32'(err_cnt - e0), 32'd1);

    // Reset in the middle of a frame clears the mask and drops the partial frame
    send_bits(make_frame(8'h32, 1'b0, 1'b0), 5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("midrst", 7'h00, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    e0 = err_cnt;
    send_bits(make_frame(8'h32, 1'b0, 1'b0), 11);
    check_outputs("post_rst", 7'h10, 8'h42);
    check("post_rst_errs", 32'(err_cnt - e0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
